// File: rtl/mist1032isa_memory_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mist1032isa_memory_arbiter_if
// Brief    : Bundle of the IF, LS and shared memory port signals around the
//            memory arbiter. The arbiter connects through the slave modport;
//            the surrounding core/memory model uses the master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface mist1032isa_memory_arbiter_if;
  // Instruction-fetch side
  logic        iIF_REQ;
  logic        oIF_LOCK;
  logic [24:0] iIF_ADDR;
  logic        oIF_VALID;
  logic        iIF_LOCK;
  logic [63:0] oIF_DATA;
  // Load/store side
  logic        iLS_REQ;
  logic        oLS_LOCK;
  logic [1:0]  iLS_ORDER;
  logic        iLS_RW;
  logic [24:0] iLS_ADDR;
  logic [31:0] iLS_DATA;
  logic        oLS_VALID;
  logic        iLS_LOCK;
  logic [63:0] oLS_DATA;
  // Shared memory port
  logic        oMEM_REQ;
  logic [1:0]  oMEM_ORDER;
  logic        oMEM_RW;
  logic [24:0] oMEM_ADDR;
  logic [31:0] oMEM_DATA;
  logic        iMEM_LOCK;
  logic        iMEM_VALID;
  logic        oMEM_LOCK;
  logic [63:0] iMEM_DATA;

  // Arbiter view
  modport slave (
    input  iIF_REQ, iIF_ADDR, iIF_LOCK,
    output oIF_LOCK, oIF_VALID, oIF_DATA,
    input  iLS_REQ, iLS_ORDER, iLS_RW, iLS_ADDR, iLS_DATA, iLS_LOCK,
    output oLS_LOCK, oLS_VALID, oLS_DATA,
    output oMEM_REQ, oMEM_ORDER, oMEM_RW, oMEM_ADDR, oMEM_DATA, oMEM_LOCK,
    input  iMEM_LOCK, iMEM_VALID, iMEM_DATA
  );

  // Requesters/memory view
  modport master (
    output iIF_REQ, iIF_ADDR, iIF_LOCK,
    input  oIF_LOCK, oIF_VALID, oIF_DATA,
    output iLS_REQ, iLS_ORDER, iLS_RW, iLS_ADDR, iLS_DATA, iLS_LOCK,
    input  oLS_LOCK, oLS_VALID, oLS_DATA,
    input  oMEM_REQ, oMEM_ORDER, oMEM_RW, oMEM_ADDR, oMEM_DATA, oMEM_LOCK,
    output iMEM_LOCK, iMEM_VALID, iMEM_DATA
  );
endinterface
`default_nettype wire

// File: rtl/mist1032isa_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mist1032isa_memory_arbiter
// Brief    : Round-robin arbiter sharing one memory port between instruction
//            fetch (IF) and load/store (LS). A tag FIFO remembers the owner
//            of every issued request so in-order responses are routed back.
// Revision : 1.0 - initial release
// ============================================================================
module mist1032isa_memory_arbiter #(
  parameter int P_TAG_DEPTH   = 4,
  parameter int P_TAG_DEPTH_N = 2
)(
  input  logic                       iCLOCK,
  input  logic                       iRESET_SYNC,
  mist1032isa_memory_arbiter_if.slave if_bus,
  output logic [P_TAG_DEPTH_N:0]     oOUTSTANDING,
  output logic                       oERROR
);

  localparam logic                     c_OWNER_IF = 1'b0;
  localparam logic                     c_OWNER_LS = 1'b1;
  localparam logic [P_TAG_DEPTH_N:0]   c_FULL     = (P_TAG_DEPTH_N+1)'(P_TAG_DEPTH);
  localparam logic [P_TAG_DEPTH_N-1:0] c_LAST     = P_TAG_DEPTH_N'(P_TAG_DEPTH-1);

  logic                     r_token;
  logic                     r_tag [P_TAG_DEPTH];
  logic [P_TAG_DEPTH_N-1:0] r_wptr;
  logic [P_TAG_DEPTH_N-1:0] r_rptr;
  logic [P_TAG_DEPTH_N:0]   r_count;
  logic                     r_error;

  logic w_empty;
  logic w_full;
  logic w_issue_ok;
  logic w_if_grant;
  logic w_ls_grant;
  logic w_push;
  logic w_pop;
  logic w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL);
  assign w_head  = r_tag[r_rptr];

  // Reset blocks issue so both requesters see LOCK while it is held; a full
  // tag FIFO blocks issue even when a pop frees a slot this cycle.
  assign w_issue_ok = !iRESET_SYNC && !if_bus.iMEM_LOCK && !w_full;
  assign w_if_grant = w_issue_ok && if_bus.iIF_REQ && (!if_bus.iLS_REQ || r_token == c_OWNER_IF);
  assign w_ls_grant = w_issue_ok && if_bus.iLS_REQ && (!if_bus.iIF_REQ || r_token == c_OWNER_LS);
  assign w_push     = w_if_grant || w_ls_grant;
  assign w_pop      = if_bus.iMEM_VALID && !w_empty;

  assign if_bus.oIF_LOCK = !w_issue_ok || (if_bus.iLS_REQ && r_token == c_OWNER_LS);
  assign if_bus.oLS_LOCK = !w_issue_ok || (if_bus.iIF_REQ && r_token == c_OWNER_IF);

  // Memory request mux: IF is always a word read, LS passes through, idle is zero.
  always_comb begin
    if_bus.oMEM_REQ   = w_push;
    if_bus.oMEM_ORDER = 2'h0;
    if_bus.oMEM_RW    = 1'b0;
    if_bus.oMEM_ADDR  = 25'h0;
    if_bus.oMEM_DATA  = 32'h0;
    if (w_if_grant) begin
      if_bus.oMEM_ORDER = 2'h2;
      if_bus.oMEM_ADDR  = if_bus.iIF_ADDR;
    end else if (w_ls_grant) begin
      if_bus.oMEM_ORDER = if_bus.iLS_ORDER;
      if_bus.oMEM_RW    = if_bus.iLS_RW;
      if_bus.oMEM_ADDR  = if_bus.iLS_ADDR;
      if_bus.oMEM_DATA  = if_bus.iLS_DATA;
    end
  end

  // Responses return in issue order, so the FIFO head names their owner.
  assign if_bus.oIF_VALID = if_bus.iMEM_VALID && !w_empty && (w_head == c_OWNER_IF);
  assign if_bus.oLS_VALID = if_bus.iMEM_VALID && !w_empty && (w_head == c_OWNER_LS);
  assign if_bus.oIF_DATA  = if_bus.iMEM_DATA;
  assign if_bus.oLS_DATA  = if_bus.iMEM_DATA;
  assign if_bus.oMEM_LOCK = w_empty ? 1'b0 :
                            ((w_head == c_OWNER_IF) ? if_bus.iIF_LOCK : if_bus.iLS_LOCK);

  assign oOUTSTANDING = r_count;
  assign oERROR       = r_error;

  // Round-robin token: after a grant the other requester gets priority.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_token <= c_OWNER_IF;
    end else if (w_push) begin
      r_token <= w_if_grant ? c_OWNER_LS : c_OWNER_IF;
    end
  end

  // Tag storage; stale entries are harmless because the pointers are reset.
  always_ff @(posedge iCLOCK) begin
    if (w_push) begin
      r_tag[r_wptr] <= w_ls_grant ? c_OWNER_LS : c_OWNER_IF;
    end
  end

  // Tag FIFO pointers and occupancy count, wrapping at the configured depth.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky flag for a response that no issued request accounts for.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_error <= 1'b0;
    end else if (if_bus.iMEM_VALID && w_empty) begin
      r_error <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mist1032isa_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mist1032isa_memory_arbiter
// Brief    : Directed bench for the IF/LS memory arbiter with a queue-based
//            reference model checked every cycle plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mist1032isa_memory_arbiter;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] w_out;
  logic       w_err;

  int total = 0;
  int bad   = 0;

  mist1032isa_memory_arbiter_if bus();

  mist1032isa_memory_arbiter #(.P_TAG_DEPTH(4), .P_TAG_DEPTH_N(2)) dut (
    .iCLOCK      (clk),
    .iRESET_SYNC (rst),
    .if_bus      (bus),
    .oOUTSTANDING(w_out),
    .oERROR      (w_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered queue of owners (0 = IF, 1 = LS), token, error.
  bit m_q[$];
  bit m_token = 1'b0;
  bit m_err   = 1'b0;

  always @(negedge clk) begin
    logic ok, gi, gl, empty, head, exp_rw;
    logic [1:0]  exp_order;
    logic [24:0] exp_addr;
    logic [31:0] exp_data;
    empty = (m_q.size() == 0);
    head  = empty ? 1'b0 : m_q[0];
    ok    = !rst && !bus.iMEM_LOCK && (m_q.size() < DEPTH);
    gi    = ok && bus.iIF_REQ && (!bus.iLS_REQ || m_token == 1'b0);
    gl    = ok && bus.iLS_REQ && (!bus.iIF_REQ || m_token == 1'b1);
    exp_order = gi ? 2'h2 : (gl ? bus.iLS_ORDER : 2'h0);
    exp_rw    = gl ? bus.iLS_RW : 1'b0;
    exp_addr  = gi ? bus.iIF_ADDR : (gl ? bus.iLS_ADDR : 25'h0);
    exp_data  = gl ? bus.iLS_DATA : 32'h0;

    check("m_if_lock",   64'(bus.oIF_LOCK),   64'(!ok || (bus.iLS_REQ && m_token)));
    check("m_ls_lock",   64'(bus.oLS_LOCK),   64'(!ok || (bus.iIF_REQ && !m_token)));
    check("m_mem_req",   64'(bus.oMEM_REQ),   64'(gi || gl));
    check("m_mem_order", 64'(bus.oMEM_ORDER), 64'(exp_order));
    check("m_mem_rw",    64'(bus.oMEM_RW),    64'(exp_rw));
    check("m_mem_addr",  64'(bus.oMEM_ADDR),  64'(exp_addr));
    check("m_mem_data",  64'(bus.oMEM_DATA),  64'(exp_data));
    check("m_if_valid",  64'(bus.oIF_VALID),  64'(bus.iMEM_VALID && !empty && head == 1'b0));
    check("m_ls_valid",  64'(bus.oLS_VALID),  64'(bus.iMEM_VALID && !empty && head == 1'b1));
    check("m_if_data",   bus.oIF_DATA,        bus.iMEM_DATA);
    check("m_ls_data",   bus.oLS_DATA,        bus.iMEM_DATA);
    check("m_mem_lock",  64'(bus.oMEM_LOCK),
          64'(empty ? 1'b0 : (head ? bus.iLS_LOCK : bus.iIF_LOCK)));
    check("m_outstanding", 64'(w_out), 64'(m_q.size()));
    check("m_error",       64'(w_err), 64'(m_err));

    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      m_q.delete();
      m_token = 1'b0;
      m_err   = 1'b0;
    end else begin
      if (bus.iMEM_VALID && empty) m_err = 1'b1;
      if (bus.iMEM_VALID && !empty) void'(m_q.pop_front());
      if (gi) begin m_q.push_back(1'b0); m_token = 1'b1; end
      if (gl) begin m_q.push_back(1'b1); m_token = 1'b0; end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iIF_REQ = 0; bus.iIF_ADDR = '0; bus.iIF_LOCK = 0;
    bus.iLS_REQ = 0; bus.iLS_ORDER = '0; bus.iLS_RW = 0; bus.iLS_ADDR = '0;
    bus.iLS_DATA = '0; bus.iLS_LOCK = 0;
    bus.iMEM_LOCK = 0; bus.iMEM_VALID = 0; bus.iMEM_DATA = '0;
  endtask

  task automatic do_reset();
    cyc();
    idle();
    rst = 1;
    #3;
    check("rst_if_lock", 64'(bus.oIF_LOCK), 64'(1));
    check("rst_ls_lock", 64'(bus.oLS_LOCK), 64'(1));
    cyc();
    rst = 0;
    #3;
    check("rst_outstanding", 64'(w_out), 64'(0));
    check("rst_error",       64'(w_err), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle();
    do_reset();

    // Single IF read and its response.
    cyc(); bus.iIF_REQ = 1; bus.iIF_ADDR = 25'h000100; #3;
    check("s1_req",   64'(bus.oMEM_REQ),   64'(1));
    check("s1_order", 64'(bus.oMEM_ORDER), 64'(2));
    check("s1_rw",    64'(bus.oMEM_RW),    64'(0));
    check("s1_addr",  64'(bus.oMEM_ADDR),  64'h100);
    check("s1_lock",  64'(bus.oIF_LOCK),   64'(0));
    cyc(); bus.iIF_REQ = 0; bus.iMEM_VALID = 1; bus.iMEM_DATA = 64'h1122334455667788; #3;
    check("s1_out1",   64'(w_out),         64'(1));
    check("s1_valid",  64'(bus.oIF_VALID), 64'(1));
    check("s1_data",   bus.oIF_DATA,       64'h1122334455667788);
    check("s1_lsv",    64'(bus.oLS_VALID), 64'(0));
    cyc(); bus.iMEM_VALID = 0; #3;
    check("s1_out0",   64'(w_out), 64'(0));

    // Continuous contention: grants alternate starting with IF.
    do_reset();
    cyc();
    bus.iIF_REQ = 1; bus.iIF_ADDR = 25'h000100;
    bus.iLS_REQ = 1; bus.iLS_ADDR = 25'h000200; bus.iLS_ORDER = 2'h2;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      bus.iMEM_VALID = (i > 0);
      bus.iMEM_DATA  = 64'(i);
      #3;
      check("s2_addr",    64'(bus.oMEM_ADDR), (i % 2 == 0) ? 64'h100 : 64'h200);
      check("s2_if_lock", 64'(bus.oIF_LOCK),  64'(i % 2 == 1));
      check("s2_ls_lock", 64'(bus.oLS_LOCK),  64'(i % 2 == 0));
      check("s2_if_val",  64'(bus.oIF_VALID), 64'(i > 0 && (i - 1) % 2 == 0));
    end
    cyc(); bus.iIF_REQ = 0; bus.iLS_REQ = 0; bus.iMEM_VALID = 1; #3;
    check("s2_last_ls", 64'(bus.oLS_VALID), 64'(1));
    cyc(); bus.iMEM_VALID = 0; #3;
    check("s2_out0", 64'(w_out), 64'(0));

    // LS byte write then IF read; responses route in issue order.
    do_reset();
    cyc(); bus.iLS_REQ = 1; bus.iLS_ORDER = 2'h0; bus.iLS_RW = 1;
    bus.iLS_ADDR = 25'h000003; bus.iLS_DATA = 32'hAB; #3;
    check("s3_order", 64'(bus.oMEM_ORDER), 64'(0));
    check("s3_rw",    64'(bus.oMEM_RW),    64'(1));
    check("s3_addr",  64'(bus.oMEM_ADDR),  64'h3);
    check("s3_wdata", 64'(bus.oMEM_DATA),  64'hAB);
    cyc(); bus.iLS_REQ = 0; bus.iIF_REQ = 1; bus.iIF_ADDR = 25'h000080; #3;
    check("s3_if_addr", 64'(bus.oMEM_ADDR), 64'h80);
    check("s3_if_data", 64'(bus.oMEM_DATA), 64'h0);
    cyc(); bus.iIF_REQ = 0; bus.iMEM_VALID = 1; bus.iMEM_DATA = 64'hD0; #3;
    check("s3_r1_ls", 64'(bus.oLS_VALID), 64'(1));
    check("s3_r1_if", 64'(bus.oIF_VALID), 64'(0));
    cyc(); bus.iMEM_DATA = 64'hD1; #3;
    check("s3_r2_if", 64'(bus.oIF_VALID), 64'(1));
    check("s3_r2_ls", 64'(bus.oLS_VALID), 64'(0));
    cyc(); bus.iMEM_VALID = 0; #3;
    check("s3_out0", 64'(w_out), 64'(0));

    // Fill the tag FIFO; a full FIFO blocks issue even on a popping cycle.
    do_reset();
    cyc(); bus.iIF_REQ = 1; bus.iIF_ADDR = 25'h000010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #3;
      check("s4_fill_req", 64'(bus.oMEM_REQ), 64'(1));
    end
    cyc(); bus.iLS_REQ = 1; bus.iLS_ADDR = 25'h000020; bus.iMEM_VALID = 1; #3;
    check("s4_full_out", 64'(w_out),         64'(4));
    check("s4_full_ifl", 64'(bus.oIF_LOCK),  64'(1));
    check("s4_full_lsl", 64'(bus.oLS_LOCK),  64'(1));
    check("s4_full_req", 64'(bus.oMEM_REQ),  64'(0));
    check("s4_full_pop", 64'(bus.oIF_VALID), 64'(1));
    cyc(); bus.iMEM_VALID = 0; #3;
    check("s4_next_req", 64'(bus.oMEM_REQ), 64'(1));
    check("s4_next_lsl", 64'(bus.oLS_LOCK), 64'(0));
    check("s4_next_out", 64'(w_out),        64'(3));
    cyc(); bus.iIF_REQ = 0; bus.iLS_REQ = 0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) cyc();
      bus.iMEM_VALID = 1;
      #3;
      check("s4_drain_if", 64'(bus.oIF_VALID), 64'(j < 3));
      check("s4_drain_ls", 64'(bus.oLS_VALID), 64'(j == 3));
    end
    cyc(); bus.iMEM_VALID = 0; #3;
    check("s4_out0", 64'(w_out), 64'(0));

    // Response back-pressure from LS, then an unexpected response.
    do_reset();
    cyc(); bus.iLS_REQ = 1; bus.iLS_ORDER = 2'h2; bus.iLS_ADDR = 25'h000040; #3;
    check("s5_req", 64'(bus.oMEM_REQ), 64'(1));
    cyc(); bus.iLS_REQ = 0; bus.iLS_LOCK = 1; #3;
    check("s5_mlock1", 64'(bus.oMEM_LOCK), 64'(1));
    check("s5_lsv1",   64'(bus.oLS_VALID), 64'(0));
    cyc(); #3;
    check("s5_mlock2", 64'(bus.oMEM_LOCK), 64'(1));
    cyc(); bus.iLS_LOCK = 0; bus.iMEM_VALID = 1; bus.iMEM_DATA = 64'hCAFE; #3;
    check("s5_mlock0", 64'(bus.oMEM_LOCK), 64'(0));
    check("s5_lsv",    64'(bus.oLS_VALID), 64'(1));
    cyc(); #3;
    check("s5_orph_ls",  64'(bus.oLS_VALID), 64'(0));
    check("s5_orph_if",  64'(bus.oIF_VALID), 64'(0));
    check("s5_orph_err", 64'(w_err),         64'(0));
    cyc(); bus.iMEM_VALID = 0; #3;
    check("s5_err",  64'(w_err), 64'(1));
    check("s5_out0", 64'(w_out), 64'(0));
    cyc(); #3;
    check("s5_err_sticky", 64'(w_err), 64'(1));

    // Reset with three requests outstanding.
    cyc(); bus.iIF_REQ = 1; bus.iIF_ADDR = 25'h000300;
    cyc(); cyc();
    cyc(); bus.iIF_REQ = 0; #3;
    check("s6_out3", 64'(w_out), 64'(3));
    cyc(); rst = 1; bus.iIF_REQ = 1; bus.iLS_REQ = 1; bus.iLS_ADDR = 25'h000400; #3;
    check("s6_rst_ifl", 64'(bus.oIF_LOCK), 64'(1));
    check("s6_rst_lsl", 64'(bus.oLS_LOCK), 64'(1));
    check("s6_rst_req", 64'(bus.oMEM_REQ), 64'(0));
    cyc(); rst = 0; #3;
    check("s6_out0",   64'(w_out),         64'(0));
    check("s6_err0",   64'(w_err),         64'(0));
    check("s6_ifl",    64'(bus.oIF_LOCK),  64'(0));
    check("s6_lsl",    64'(bus.oLS_LOCK),  64'(1));
    check("s6_addr",   64'(bus.oMEM_ADDR), 64'h300);
    cyc(); bus.iIF_REQ = 0; bus.iLS_REQ = 0; bus.iMEM_VALID = 1; #3;
    check("s6_resp", 64'(bus.oIF_VALID), 64'(1));
    cyc(); bus.iMEM_VALID = 0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mist1032isa_memory_arbiter.md
MIST1032ISA_MEMORY_ARBITER -- requirements
Module: mist1032isa_memory_arbiter

Interface
REQ-001 The block SHALL have parameter P_TAG_DEPTH, default 4, the number of outstanding memory requests tracked.
REQ-002 The block SHALL have parameter P_TAG_DEPTH_N, default 2, equal to log2(P_TAG_DEPTH).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- iCLOCK  in  1  clock; all state changes on its rising edge.
- iRESET_SYNC  in  1  synchronous, active-high reset.
- iIF_REQ  in  1  instruction-fetch request (read only).
- oIF_LOCK  out  1  IF request not accepted this cycle; IF holds its request.
- iIF_ADDR  in  25  IF byte address.
- oIF_VALID  out  1  response data valid for IF.
- iIF_LOCK  in  1  IF cannot take a response.
- oIF_DATA  out  64  IF response data.
- iLS_REQ  in  1  load/store request.
- oLS_LOCK  out  1  LS request not accepted this cycle.
- iLS_ORDER  in  2  access size: 00 byte, 01 halfword, 10 word.
- iLS_RW  in  1  1 = write, 0 = read.
- iLS_ADDR  in  25  LS byte address.
- iLS_DATA  in  32  LS write data.
- oLS_VALID  out  1  response valid for LS.
- iLS_LOCK  in  1  LS cannot take a response.
- oLS_DATA  out  64  LS response data.
- oMEM_REQ, oMEM_ORDER[1:0], oMEM_RW, oMEM_ADDR[24:0], oMEM_DATA[31:0]  out  request to the shared memory port.
- iMEM_LOCK  in  1  memory cannot accept a request.
- iMEM_VALID  in  1  memory response valid; consumed in the same cycle.
- oMEM_LOCK  out  1  stalls memory responses.
- iMEM_DATA  in  64  memory response data.
- oOUTSTANDING  out  P_TAG_DEPTH_N+1  number of tag FIFO entries.
- oERROR  out  1  sticky flag: a response arrived with no outstanding tag.

Function
REQ-004 The block SHALL define issue_ok = !iMEM_LOCK && (oOUTSTANDING != P_TAG_DEPTH).
REQ-005 The block SHALL keep a 1-bit round-robin token (0 = IF, 1 = LS); on a tie, the owner of the token wins.
REQ-006 The block SHALL grant IF when issue_ok && iIF_REQ && (!iLS_REQ || token==IF), and SHALL grant LS when issue_ok && iLS_REQ && (!iIF_REQ || token==LS); at most one grant SHALL be issued per cycle.
REQ-007 The block SHALL drive oIF_LOCK = !issue_ok || (iLS_REQ && token==LS) and oLS_LOCK = !issue_ok || (iIF_REQ && token==IF), combinationally.
REQ-008 The block SHALL drive oMEM_REQ high only on a grant cycle.
REQ-009 On an IF grant, the memory request fields SHALL be ORDER=2'h2, RW=0, ADDR=iIF_ADDR, DATA=32'h0.
REQ-010 On an LS grant, the memory request fields SHALL carry the LS fields unchanged.
REQ-011 With no grant, the memory request fields SHALL be 0.
REQ-012 On every grant, the token SHALL flip to the non-granted requester; otherwise the token SHALL hold.
REQ-013 On every grant, the block SHALL push the owner ID into the tag FIFO (depth P_TAG_DEPTH, in order).
REQ-014 Every memory request, read or write, SHALL produce exactly one response, and responses SHALL return in issue order.
REQ-015 Responses SHALL be routed combinationally: oIF_VALID = iMEM_VALID && !empty && head==IF; oLS_VALID likewise for LS.
REQ-016 oIF_DATA and oLS_DATA SHALL both equal iMEM_DATA.
REQ-017 oMEM_LOCK SHALL equal iIF_LOCK when head==IF, iLS_LOCK when head==LS, and 0 when the tag FIFO is empty.
REQ-018 The block SHALL pop the tag FIFO on iMEM_VALID && !empty.
REQ-019 If push and pop occur in the same cycle, the count SHALL be unchanged.
REQ-020 When the tag FIFO is full, no grant SHALL be issued even if a pop occurs in the same cycle.
REQ-021 On iMEM_VALID with an empty tag FIFO, the block SHALL set oERROR (sticky), route the response to neither requester, and leave the count unchanged.
REQ-022 Read and write pointers SHALL wrap modulo P_TAG_DEPTH.
REQ-023 oOUTSTANDING SHALL equal pushes minus pops since reset.

Reset
REQ-024 With iRESET_SYNC high at a clock edge, the block SHALL reset: token=IF, tag FIFO empty, oOUTSTANDING=0, oERROR=0.
REQ-025 While iRESET_SYNC is high, no grant SHALL be issued, and oIF_LOCK=oLS_LOCK=1.
REQ-026 A reset mid-operation SHALL discard all outstanding tags; the memory port is reset by the same system reset.

Verification
REQ-027 Idle after reset, IF requests 0x000100 -> same cycle oMEM_REQ=1, ORDER=2, RW=0, ADDR=0x000100, oIF_LOCK=0; oOUTSTANDING=1 next cycle; response 0x1122334455667788 -> oIF_VALID=1 with that data, oOUTSTANDING=0.
REQ-028 IF and LS request continuously for 6 cycles with memory always ready and responding -> grants alternate IF, LS, IF, LS, IF, LS; the losing requester's LOCK=1 on each cycle.
REQ-029 LS writes byte 0xAB to 0x000003, then IF read issues -> responses arrive in order: first oLS_VALID, then oIF_VALID; no cross-routing.
REQ-030 Four grants with no responses -> oOUTSTANDING=4, both LOCKs=1, oMEM_REQ=0; a response that cycle pops, and the grant follows on the next cycle.
REQ-031 Head owner LS with iLS_LOCK=1 -> oMEM_LOCK=1 and oLS_VALID=0 until iLS_LOCK falls; iMEM_VALID with an empty FIFO -> oERROR=1 until reset.
REQ-032 Reset asserted with 3 outstanding -> next cycle oOUTSTANDING=0, token=IF, oERROR=0.
